// File: rtl/clause_check_scheduler_if.sv
// Handshake bundle between the clause check scheduler, the clause memory,
// the OneClauseChecker and the MCMC sampler control.
interface clause_check_scheduler_if #(
    parameter int MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX = 3
);
    localparam int W = MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX;

    logic         in_start;
    logic         in_abort;
    logic [W:0]   in_num_clauses;
    logic         out_mem_rd_en;
    logic [W-1:0] out_mem_addr;
    logic         out_checker_enable;
    logic         in_checker_ready;
    logic         in_checker_satisfied;
    logic         out_busy;
    logic         out_done;
    logic         out_all_satisfied;
    logic [W:0]   out_unsat_count;
    logic         out_first_unsat_valid;
    logic [W-1:0] out_first_unsat_idx;
    logic         out_error;

    // Scheduler side
    modport slave (
        input  in_start, in_abort, in_num_clauses, in_checker_ready, in_checker_satisfied,
        output out_mem_rd_en, out_mem_addr, out_checker_enable, out_busy, out_done,
               out_all_satisfied, out_unsat_count, out_first_unsat_valid,
               out_first_unsat_idx, out_error
    );

    // Sampler control / memory / checker side
    modport master (
        output in_start, in_abort, in_num_clauses, in_checker_ready, in_checker_satisfied,
        input  out_mem_rd_en, out_mem_addr, out_checker_enable, out_busy, out_done,
               out_all_satisfied, out_unsat_count, out_first_unsat_valid,
               out_first_unsat_idx, out_error
    );
endinterface

// File: rtl/clause_check_scheduler.sv
// Clause check scheduler: walks one OneClauseChecker over every active clause
// (FETCH -> CHECK -> WAIT per clause, three cycles each) and reports done,
// all-satisfied, unsat count, first unsat index and checker-timeout error.
// Optional feature: define CLAUSE_SCHED_EARLY_EXIT_EN to finish the scan on
// the first unsatisfied clause instead of scanning every active clause.
module clause_check_scheduler #(
    parameter int MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX = 3,
    parameter int WAIT_TIMEOUT                       = 15
) (
    input logic                     in_clk,
    input logic                     in_reset_n,
    clause_check_scheduler_if.slave bus
);
    localparam int W  = MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX;
    localparam int TW = $clog2(WAIT_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_CHECK = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        state;
    logic [W-1:0]  idx;
    logic [W:0]    num;
    logic [TW-1:0] tcnt;

    logic          rd_en_r;
    logic [W-1:0]  addr_r;
    logic          enable_r;
    logic          busy_r;
    logic          done_r;
    logic          all_sat_r;
    logic [W:0]    unsat_cnt_r;
    logic          first_vld_r;
    logic [W-1:0]  first_idx_r;
    logic          error_r;

    logic          wait_last;
    logic          finish_scan;
    logic [TW-1:0] tcnt_inc;
    logic [W-1:0]  idx_inc;

    // idx is W bits and num up to 2**W, so compare in W+1 bits to let the
    // last index 2**W-1 terminate without wrapping.
    assign wait_last = ({1'b0, idx} == (num - 1'b1));
    assign tcnt_inc  = tcnt + 1'b1;
    assign idx_inc   = idx + 1'b1;

`ifdef CLAUSE_SCHED_EARLY_EXIT_EN
    assign finish_scan = wait_last || !bus.in_checker_satisfied;
`else
    assign finish_scan = wait_last;
`endif

    // Scan FSM with registered outputs; abort overrides everything outside IDLE.
    always_ff @(posedge in_clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            state       <= S_IDLE;
            idx         <= '0;
            num         <= '0;
            tcnt        <= '0;
            rd_en_r     <= 1'b0;
            addr_r      <= '0;
            enable_r    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            all_sat_r   <= 1'b0;
            unsat_cnt_r <= '0;
            first_vld_r <= 1'b0;
            first_idx_r <= '0;
            error_r     <= 1'b0;
        end else begin
            done_r  <= 1'b0;
            rd_en_r <= 1'b0;
            if (state != S_IDLE && bus.in_abort) begin
                state       <= S_IDLE;
                idx         <= '0;
                tcnt        <= '0;
                addr_r      <= '0;
                enable_r    <= 1'b0;
                busy_r      <= 1'b0;
                all_sat_r   <= 1'b0;
                unsat_cnt_r <= '0;
                first_vld_r <= 1'b0;
                first_idx_r <= '0;
                error_r     <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.in_start) begin
                            num         <= bus.in_num_clauses;
                            idx         <= '0;
                            addr_r      <= '0;
                            busy_r      <= 1'b1;
                            unsat_cnt_r <= '0;
                            first_vld_r <= 1'b0;
                            first_idx_r <= '0;
                            error_r     <= 1'b0;
                            if (bus.in_num_clauses == '0) begin
                                // Empty formula is trivially satisfied.
                                state     <= S_DONE;
                                done_r    <= 1'b1;
                                all_sat_r <= 1'b1;
                            end else begin
                                state     <= S_FETCH;
                                rd_en_r   <= 1'b1;
                                all_sat_r <= 1'b0;
                            end
                        end
                    end
                    S_FETCH: begin
                        // Clause word arrives from memory during CHECK.
                        state    <= S_CHECK;
                        enable_r <= 1'b1;
                    end
                    S_CHECK: begin
                        state <= S_WAIT;
                        tcnt  <= '0;
                    end
                    S_WAIT: begin
                        if (bus.in_checker_ready) begin
                            if (!bus.in_checker_satisfied) begin
                                unsat_cnt_r <= unsat_cnt_r + 1'b1;
                                if (!first_vld_r) begin
                                    first_vld_r <= 1'b1;
                                    first_idx_r <= idx;
                                end
                            end
                            // Dropping enable clears the checker's ready flag
                            // before the next clause reaches WAIT.
                            enable_r <= 1'b0;
                            if (finish_scan) begin
                                state     <= S_DONE;
                                done_r    <= 1'b1;
                                all_sat_r <= bus.in_checker_satisfied && (unsat_cnt_r == '0);
                            end else begin
                                state   <= S_FETCH;
                                idx     <= idx_inc;
                                addr_r  <= idx_inc;
                                rd_en_r <= 1'b1;
                            end
                        end else if (tcnt_inc == TW'(WAIT_TIMEOUT)) begin
                            state     <= S_DONE;
                            done_r    <= 1'b1;
                            error_r   <= 1'b1;
                            all_sat_r <= 1'b0;
                            enable_r  <= 1'b0;
                        end else begin
                            tcnt <= tcnt_inc;
                        end
                    end
                    S_DONE: begin
                        state  <= S_IDLE;
                        busy_r <= 1'b0;
                    end
                    default: begin
                        state    <= S_IDLE;
                        busy_r   <= 1'b0;
                        enable_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.out_mem_rd_en         = rd_en_r;
    assign bus.out_mem_addr          = addr_r;
    assign bus.out_checker_enable    = enable_r;
    assign bus.out_busy              = busy_r;
    assign bus.out_done              = done_r;
    assign bus.out_all_satisfied     = all_sat_r;
    assign bus.out_unsat_count       = unsat_cnt_r;
    assign bus.out_first_unsat_valid = first_vld_r;
    assign bus.out_first_unsat_idx   = first_idx_r;
    assign bus.out_error             = error_r;

endmodule

// File: tb/tb_clause_check_scheduler.sv
// Directed bench for clause_check_scheduler with a behavioural checker model
// and a scoreboard of expected scan results.
module tb_clause_check_scheduler;
    localparam int W = 3;

    logic clk;
    logic rst_n;

    clause_check_scheduler_if #(.MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX(W)) bus ();

    clause_check_scheduler #(
        .MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX(W),
        .WAIT_TIMEOUT(15)
    ) dut (
        .in_clk(clk),
        .in_reset_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Checker model: per-clause unsat mask, ready one cycle after enabled sample.
    logic [7:0]   mask;
    logic         healthy;
    logic [W-1:0] cur_addr;

    // Behavioural OneClauseChecker plus clause memory address capture
    always @(posedge clk) begin
        if (bus.out_mem_rd_en) cur_addr <= bus.out_mem_addr;
        if (!bus.out_checker_enable) begin
            bus.in_checker_ready <= 1'b0;
        end else if (healthy && !bus.in_checker_ready) begin
            bus.in_checker_ready     <= 1'b1;
            bus.in_checker_satisfied <= !mask[cur_addr];
        end
    end

    typedef struct {
        int cyc;
        int all_sat;
        int count;
        int fvld;
        int fidx;
        int err;
        int rd;
        int en;
    } exp_t;

    exp_t sb[$];
    int checks;
    int failures;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int n, input logic [7:0] m, input logic h);
        exp_t e;
        bit stop;
        e = '{cyc: 0, all_sat: 0, count: 0, fvld: 0, fidx: 0, err: 0, rd: 0, en: 0};
        stop = 0;
        if (n == 0) begin
            e.cyc = 1;
            e.all_sat = 1;
        end else if (!h) begin
            e.cyc = 18;
            e.err = 1;
            e.rd = 1;
            e.en = 16;
        end else begin
            e.cyc = 3 * n + 1;
            e.rd = n;
            for (int i = 0; i < n; i++) begin
                if (!stop && m[i]) begin
                    e.count++;
                    if (e.fvld == 0) begin
                        e.fvld = 1;
                        e.fidx = i;
                    end
`ifdef CLAUSE_SCHED_EARLY_EXIT_EN
                    stop = 1;
                    e.cyc = 3 * (i + 1) + 1;
                    e.rd = i + 1;
`endif
                end
            end
            e.en = 2 * e.rd;
            e.all_sat = (e.count == 0) ? 1 : 0;
        end
        return e;
    endfunction

    task automatic run_scan(input string tag, input int n, input logic [7:0] m,
                            input logic h, input int spur);
        exp_t e;
        int cyc;
        int rd;
        int en;
        bit seen;
        sb.push_back(model(n, m, h));
        mask = m;
        healthy = h;
        bus.in_num_clauses = 4'(n);
        bus.in_start = 1'b1;
        cyc = 0;
        rd = 0;
        en = 0;
        seen = 0;
        while (!seen && cyc < 200) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            bus.in_start = (spur == cyc);
            if (spur == cyc) bus.in_num_clauses = 4'd1;
            rd += int'(bus.out_mem_rd_en);
            en += int'(bus.out_checker_enable);
            if (bus.out_done) seen = 1;
        end
        e = sb.pop_front();
        check({tag, "_done_seen"}, int'(seen), 1);
        check({tag, "_done_cycle"}, cyc, e.cyc);
        check({tag, "_busy_at_done"}, int'(bus.out_busy), 1);
        check({tag, "_all_sat"}, int'(bus.out_all_satisfied), e.all_sat);
        check({tag, "_unsat_count"}, int'(bus.out_unsat_count), e.count);
        check({tag, "_first_vld"}, int'(bus.out_first_unsat_valid), e.fvld);
        check({tag, "_first_idx"}, int'(bus.out_first_unsat_idx), e.fidx);
        check({tag, "_error"}, int'(bus.out_error), e.err);
        check({tag, "_rd_pulses"}, rd, e.rd);
        check({tag, "_en_cycles"}, en, e.en);
        @(posedge clk);
        @(negedge clk);
        bus.in_start = 1'b0;
        check({tag, "_done_width"}, int'(bus.out_done), 0);
        check({tag, "_busy_after"}, int'(bus.out_busy), 0);
        check({tag, "_all_sat_hold"}, int'(bus.out_all_satisfied), e.all_sat);
        check({tag, "_count_hold"}, int'(bus.out_unsat_count), e.count);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_idle_busy"}, int'(bus.out_busy), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, int'(bus.out_busy), 0);
        check({tag, "_done"}, int'(bus.out_done), 0);
        check({tag, "_rd_en"}, int'(bus.out_mem_rd_en), 0);
        check({tag, "_addr"}, int'(bus.out_mem_addr), 0);
        check({tag, "_enable"}, int'(bus.out_checker_enable), 0);
        check({tag, "_all_sat"}, int'(bus.out_all_satisfied), 0);
        check({tag, "_count"}, int'(bus.out_unsat_count), 0);
        check({tag, "_first_vld"}, int'(bus.out_first_unsat_valid), 0);
        check({tag, "_first_idx"}, int'(bus.out_first_unsat_idx), 0);
        check({tag, "_error"}, int'(bus.out_error), 0);
    endtask

    initial begin
        int any_done;
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        mask = 8'h00;
        healthy = 1'b1;
        cur_addr = '0;
        bus.in_start = 1'b0;
        bus.in_abort = 1'b0;
        bus.in_num_clauses = '0;
        bus.in_checker_ready = 1'b0;
        bus.in_checker_satisfied = 1'b0;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("post_reset");

        // All four clauses satisfied; a start pulse in the DONE cycle is ignored.
        run_scan("n4_sat", 4, 8'h00, 1'b1, 13);
        // Clauses 2 and 5 unsatisfied; start pulse while busy is ignored.
        run_scan("n8_unsat", 8, 8'b0010_0100, 1'b1, 5);
        // Empty formula.
        run_scan("n0", 0, 8'h00, 1'b1, 0);
        // Checker never ready: timeout error, then next start clears it.
        run_scan("timeout", 3, 8'h00, 1'b0, 0);
        run_scan("after_to", 2, 8'h00, 1'b1, 0);

        // Abort during the WAIT of clause 3.
`ifdef CLAUSE_SCHED_EARLY_EXIT_EN
        mask = 8'h00;
`else
        mask = 8'b0000_0010;
`endif
        healthy = 1'b1;
        bus.in_num_clauses = 4'd8;
        bus.in_start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            @(negedge clk);
            bus.in_start = (c == 7);
        end
        check("abort_pre_enable", int'(bus.out_checker_enable), 1);
        check("abort_pre_ready", int'(bus.in_checker_ready), 1);
`ifdef CLAUSE_SCHED_EARLY_EXIT_EN
        check("abort_pre_count", int'(bus.out_unsat_count), 0);
`else
        check("abort_pre_count", int'(bus.out_unsat_count), 1);
`endif
        bus.in_abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_abort = 1'b0;
        check_all_zero("abort");
        any_done = 0;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            any_done += int'(bus.out_done) + int'(bus.out_busy);
        end
        check("abort_quiet", any_done, 0);
        run_scan("post_abort", 5, 8'b0001_0000, 1'b1, 4);

        // Asynchronous reset in the middle of a CHECK cycle.
        mask = 8'h00;
        bus.in_num_clauses = 4'd4;
        bus.in_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_start = 1'b0;
        @(posedge clk);
        #1;
        check("rst_pre_enable", int'(bus.out_checker_enable), 1);
        check("rst_pre_busy", int'(bus.out_busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("rst_release");

        // Full-width scan; last index 2**W-1 unsatisfied.
        run_scan("n8_last", 8, 8'h80, 1'b1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
